// File: rtl/cache_refill_responder.sv
// cache_refill_responder: line-refill responder with programmable latency, valid/ready beat burst and preload write port (CRITICAL_WORD_FIRST_EN: burst starts at requested word and wraps)
module cache_refill_responder #(
  parameter int ADDR_W = 32,
  parameter int BEATS = 4,
  parameter int MEM_WORDS = 256,
  parameter int LATENCY = 3,
  localparam int BW = $clog2(BEATS),
  localparam int MW = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [BW-1:0]     rsp_beat,
  output logic              rsp_last,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [31:0]       mem_wdata
);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;
  state_t state;
  logic [31:0] mem [MEM_WORDS];
  logic [MW-1:0] req_base, base, ld_base, ld_idx;
  logic [BW-1:0] req_off, off, ld_off, n, n_next;
  logic [CW-1:0] wcnt;
  logic load;
  logic unused;
  assign req_base = {req_addr[MW+1:BW+2], {BW{1'b0}}};
`ifdef CRITICAL_WORD_FIRST_EN
  assign req_off = req_addr[BW+1:2];
`else
  assign req_off = '0;
`endif
  assign unused = ^{req_addr, mem_waddr};
  assign req_ready = state == IDLE && !reset;
  always_comb begin
    ld_base = state == IDLE ? req_base : base;
    ld_off = state == IDLE ? req_off : state == WAIT ? off : rsp_beat + 1'b1;
    ld_idx = ld_base | MW'(ld_off);
    n_next = state == BURST ? n + 1'b1 : '0;
    load = state == IDLE ? req_valid && LATENCY == 0 : state == WAIT ? wcnt == '0 : rsp_ready && !rsp_last;
  end
  always_ff @(posedge clk)
    if (mem_we) mem[mem_waddr[MW+1:2]] <= mem_wdata;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_beat <= '0;
      rsp_last <= 1'b0;
      base <= '0;
      off <= '0;
      n <= '0;
      wcnt <= '0;
    end else begin
      if (load) begin
        rsp_valid <= 1'b1;
        rsp_data <= mem[ld_idx];
        rsp_beat <= ld_off;
        rsp_last <= n_next == LAST;
        n <= n_next;
      end
      case (state)
        IDLE:
          if (req_valid) begin
            base <= req_base;
            off <= req_off;
            wcnt <= CW'(LATENCY - 1);
            state <= LATENCY == 0 ? BURST : WAIT;
          end
        WAIT: begin
          wcnt <= wcnt - 1'b1;
          if (wcnt == '0) state <= BURST;
        end
        BURST:
          if (rsp_ready && rsp_last) begin
            state <= IDLE;
            rsp_valid <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cache_refill_responder.sv
// tb_cache_refill_responder: randomized and directed checks of cache_refill_responder against a line-level reference model
module tb_cache_refill_responder;
  localparam int LAT = 3;
  localparam int BEATS = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic rsp_ready = 1'b0;
  logic mem_we = 1'b0;
  logic [31:0] mem_waddr = '0;
  logic [31:0] mem_wdata = '0;
  logic sel = 1'b0;
  logic rdy_a, val_a, last_a, rdy_b, val_b, last_b;
  logic [31:0] dat_a, dat_b;
  logic [1:0] beat_a, beat_b;
  logic o_rdy, o_val, o_last;
  logic [31:0] o_dat;
  logic [1:0] o_beat;
  logic [31:0] mdl [256];
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  cache_refill_responder #(.LATENCY(LAT)) u_a (
    .clk(clk), .reset(reset), .req_valid(req_valid && !sel), .req_ready(rdy_a), .req_addr(req_addr),
    .rsp_valid(val_a), .rsp_ready(rsp_ready), .rsp_data(dat_a), .rsp_beat(beat_a), .rsp_last(last_a),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );
  cache_refill_responder #(.LATENCY(0)) u_b (
    .clk(clk), .reset(reset), .req_valid(req_valid && sel), .req_ready(rdy_b), .req_addr(req_addr),
    .rsp_valid(val_b), .rsp_ready(rsp_ready), .rsp_data(dat_b), .rsp_beat(beat_b), .rsp_last(last_b),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );
  assign o_rdy = sel ? rdy_b : rdy_a;
  assign o_val = sel ? val_b : val_a;
  assign o_last = sel ? last_b : last_a;
  assign o_dat = sel ? dat_b : dat_a;
  assign o_beat = sel ? beat_b : beat_a;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic int off_of(input logic [31:0] a, input int k);
    int w = int'((a >> 2) % 256);
    int o0;
`ifdef CRITICAL_WORD_FIRST_EN
    o0 = w % BEATS;
`else
    o0 = 0;
`endif
    return (o0 + k) % BEATS;
  endfunction
  function automatic int word_of(input logic [31:0] a, input int k);
    int w = int'((a >> 2) % 256);
    return w - w % BEATS + off_of(a, k);
  endfunction
  task automatic mem_wr(input int w, input logic [31:0] d);
    mem_we = 1'b1;
    mem_waddr = ($urandom & 32'hFFFF_FC03) | (32'(w) << 2);
    mem_wdata = d;
    mdl[w] = d;
    @(posedge clk);
    #1 mem_we = 1'b0;
  endtask
  task automatic run_line(input logic [31:0] addr, input bit rnd, input int stall_beat, input int stall_len,
                          input int wr_beat, input int wr_word, input logic [31:0] wr_data, input bit hold);
    int lat = sel ? 0 : LAT;
    int wait_n = 0;
    int stalls, w;
    bit rdy, we, done;
    logic [31:0] exp_d, exp_n, d;
    req_valid = 1'b1;
    req_addr = addr;
    check("req_ready_idle", o_rdy, 1);
    @(posedge clk);
    #1 req_valid = hold;
    if (hold) req_addr = 32'h0000_0040;
    while (!o_val && wait_n < 50) begin
      check("req_ready_busy", o_rdy, 0);
      @(posedge clk);
      #1 wait_n++;
    end
    check("latency", wait_n, lat);
    if (!o_val) return;
    exp_d = mdl[word_of(addr, 0)];
    exp_n = exp_d;
    for (int k = 0; k < BEATS; k++) begin
      stalls = 0;
      done = 1'b0;
      while (!done) begin
        rdy = rnd ? ($urandom_range(2) != 0 || stalls >= 6) : !(k == stall_beat && stalls < stall_len);
        we = 1'b0;
        w = 0;
        d = '0;
        if (k == wr_beat && stalls == 0) begin
          we = 1'b1;
          w = wr_word;
          d = wr_data;
        end else if (rnd && $urandom_range(2) == 0) begin
          we = 1'b1;
          w = $urandom_range(1) != 0 ? word_of(addr, int'($urandom_range(3))) : int'($urandom_range(255));
          d = $urandom;
        end
        rsp_ready = rdy;
        mem_we = we;
        mem_waddr = ($urandom & 32'hFFFF_FC03) | (32'(w) << 2);
        mem_wdata = d;
        check("rsp_valid", o_val, 1);
        check("rsp_beat", o_beat, off_of(addr, k));
        check("rsp_data", o_dat, exp_d);
        check("rsp_last", o_last, k == BEATS - 1);
        check("req_ready_burst", o_rdy, 0);
        if (rdy && k < BEATS - 1) exp_n = mdl[word_of(addr, k + 1)];
        if (we) mdl[w] = d;
        @(posedge clk);
        #1 mem_we = 1'b0;
        stalls++;
        done = rdy;
      end
      exp_d = exp_n;
    end
    rsp_ready = 1'b0;
    check("rsp_valid_end", o_val, 0);
    check("req_ready_end", o_rdy, 1);
  endtask
  initial begin
    int wait_n;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", rdy_a, 0);
    check("rst_rsp_valid", val_a, 0);
    check("rst_rsp_data", dat_a, 0);
    check("rst_rsp_beat", beat_a, 0);
    check("rst_rsp_last", last_a, 0);
    reset = 1'b0;
    #1 check("rel_req_ready", rdy_a, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) mem_wr(i, $urandom);
    mem_wr(32'h7C, 32'h1111_1111);
    mem_wr(32'h7D, 32'h2222_2222);
    mem_wr(32'h7E, 32'h3333_3333);
    mem_wr(32'h7F, 32'h4444_4444);
    run_line(32'hF9A7_C1F0, 0, -1, 0, -1, 0, '0, 0);
    run_line(32'hF9A7_C1F8, 0, -1, 0, -1, 0, '0, 0);
    run_line(32'hF9A7_C1F0, 0, 1, 5, 1, word_of(32'hF9A7_C1F0, 1), 32'h5555_AAAA, 0);
    run_line(32'h1234_5600, 0, -1, 0, -1, 0, '0, 1);
    run_line(32'h0000_0040, 0, -1, 0, -1, 0, '0, 0);
    run_line(32'hF9A7_C1F0, 0, -1, 0, 0, 32'h7F, 32'hDEAD_BEEF, 0);
    check("hazard_model", mdl[32'h7F], 32'hDEAD_BEEF);
    sel = 1'b1;
    run_line(32'hF9A7_C1F0, 0, -1, 0, -1, 0, '0, 0);
    run_line(32'h0000_0338, 0, 2, 3, -1, 0, '0, 0);
    sel = 1'b0;
    req_valid = 1'b1;
    req_addr = 32'h0000_0200;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_n = 0;
    while (!val_a && wait_n < 50) begin
      @(posedge clk);
      #1 wait_n++;
    end
    check("abort_latency", wait_n, LAT);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check("abort_beat1", beat_a, off_of(32'h0000_0200, 1));
    reset = 1'b1;
    #1;
    check("abort_rsp_valid", val_a, 0);
    check("abort_req_ready", rdy_a, 0);
    check("abort_rsp_data", dat_a, 0);
    check("abort_rsp_last", last_a, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1 check("abort_rel_ready", rdy_a, 1);
    run_line(32'h0000_0100, 0, -1, 0, -1, 0, '0, 0);
    repeat (40) begin
      sel = $urandom_range(3) == 0;
      run_line($urandom, 1, -1, 0, -1, 0, '0, 0);
      repeat ($urandom_range(2)) begin
        @(posedge clk);
        #1;
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
